// File: rtl/key_bounce_gen.sv
// rtl/key_bounce_gen.sv - mechanical key emulator: LFSR-timed contact bounce, then a settle hold
// Each command drives the key line to its target level through a burst of randomly spaced toggles, then holds it.
module key_bounce_gen #(
    parameter int          BOUNCE_N       = 10,
    parameter int          BOUNCE_W       = 4,
    parameter int          PRESS_SETTLE   = 100,
    parameter int          RELEASE_SETTLE = 200,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_press,
    output logic cmd_ready,
    output logic key,
    output logic busy,
    output logic done
);

    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam int          TOG_W      = (BOUNCE_N < 1) ? 1 : $clog2(BOUNCE_N + 1);
    localparam int          SETTLE_MAX = (PRESS_SETTLE > RELEASE_SETTLE) ? PRESS_SETTLE : RELEASE_SETTLE;
    localparam int          SET_W      = (SETTLE_MAX < 1) ? 1 : $clog2(SETTLE_MAX + 1);
    localparam bit          NO_BOUNCE  = (BOUNCE_N == 0);

    localparam logic [TOG_W-1:0]    TOG_LOAD     = TOG_W'(BOUNCE_N);
    localparam logic [SET_W-1:0]    PRESS_LOAD   = SET_W'(PRESS_SETTLE);
    localparam logic [SET_W-1:0]    RELEASE_LOAD = SET_W'(RELEASE_SETTLE);
    localparam logic [SET_W-1:0]    SET_ONE      = SET_W'(1);
    localparam logic [TOG_W-1:0]    TOG_ONE      = TOG_W'(1);
    localparam logic [BOUNCE_W-1:0] IV_ONE       = BOUNCE_W'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BOUNCE = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    logic [1:0]          state;
    logic [15:0]         lfsr;
    logic                target;
    logic [TOG_W-1:0]    toggles_left;
    logic [BOUNCE_W-1:0] interval_cnt;
    logic [SET_W-1:0]    settle_cnt;

    logic                lfsr_fb;
    logic [BOUNCE_W-1:0] interval_load;
    logic                cmd_target;
    logic [SET_W-1:0]    cmd_settle_load;
    logic [SET_W-1:0]    tgt_settle_load;

    assign lfsr_fb         = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // A zero draw would mean an instant toggle; stretch it to the shortest real interval.
    assign interval_load   = (lfsr[BOUNCE_W-1:0] == '0) ? IV_ONE : lfsr[BOUNCE_W-1:0];
    assign cmd_target      = ~cmd_press;
    assign cmd_settle_load = cmd_target ? RELEASE_LOAD : PRESS_LOAD;
    assign tgt_settle_load = target ? RELEASE_LOAD : PRESS_LOAD;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            key          <= 1'b1;
            done         <= 1'b0;
            target       <= 1'b1;
            lfsr         <= SEED_EFF;
            toggles_left <= '0;
            interval_cnt <= '0;
            settle_cnt   <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        target <= cmd_target;
                        if (cmd_target == key) begin
                            state      <= SETTLE;
                            settle_cnt <= cmd_settle_load;
                        end else if (NO_BOUNCE) begin
                            key        <= cmd_target;
                            state      <= SETTLE;
                            settle_cnt <= cmd_settle_load;
                        end else begin
                            toggles_left <= TOG_LOAD;
                            interval_cnt <= interval_load;
                            state        <= BOUNCE;
                        end
                    end
                end
                BOUNCE: begin
                    // Final edge lands one cycle after the last toggle, whatever level the toggles left.
                    if (toggles_left == '0) begin
                        key        <= target;
                        state      <= SETTLE;
                        settle_cnt <= tgt_settle_load;
                    end else if (interval_cnt <= IV_ONE) begin
                        key          <= ~key;
                        toggles_left <= toggles_left - TOG_ONE;
                        interval_cnt <= interval_load;
                    end else begin
                        interval_cnt <= interval_cnt - IV_ONE;
                    end
                end
                SETTLE: begin
                    // The done cycle stays in SETTLE so a command during it is not taken.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt <= SET_ONE) begin
                        done <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - SET_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb/tb_key_bounce_gen.sv - randomized check of key_bounce_gen against an event-schedule model
module tb_key_bounce_gen;

    localparam int BN = 10;
    localparam int PS = 100;
    localparam int RS = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_press = 1'b0;
    logic cmd_ready, key, busy, done;
    logic cmd_valid0 = 1'b0, cmd_press0 = 1'b0;
    logic cmd_ready0, key0, busy0, done0;

    int checks = 0;
    int errors = 0;

    key_bounce_gen #(.BOUNCE_N(BN), .BOUNCE_W(4), .PRESS_SETTLE(PS), .RELEASE_SETTLE(RS),
                     .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_press(cmd_press),
        .cmd_ready(cmd_ready), .key(key), .busy(busy), .done(done));

    key_bounce_gen #(.BOUNCE_N(0), .BOUNCE_W(4), .PRESS_SETTLE(7), .RELEASE_SETTLE(9),
                     .SEED(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_press(cmd_press0),
        .cmd_ready(cmd_ready0), .key(key0), .busy(busy0), .done(done0));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Model: on accept, precompute the edge times of the whole operation.
    int          cyc = 0;
    bit          m_on = 0, active = 0;
    logic        m_key = 1'b1, m_done = 1'b0, m_busy = 1'b0, m_tgt = 1'b1;
    logic [15:0] m_lfsr = 16'hACE1;
    int          tq[$];
    int          fin_t = -1, done_t = -1, idle_t = -1, st = 0, pt = 0, piv = 0;
    logic [15:0] pl;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_on = 1; active = 0; m_key = 1'b1; m_done = 1'b0; m_busy = 1'b0;
            m_lfsr = 16'hACE1; tq.delete();
        end else if (m_on) begin
            if (active) begin
                if (tq.size() > 0 && tq[0] == cyc) begin
                    m_key = ~m_key;
                    void'(tq.pop_front());
                end
                if (cyc == fin_t) m_key = m_tgt;
                m_done = (cyc == done_t);
                if (cyc == idle_t) begin
                    active = 0;
                    m_busy = 1'b0;
                end
            end else if (cmd_valid) begin
                m_tgt = ~cmd_press;
                fin_t = -1;
                tq.delete();
                if (m_tgt == m_key) begin
                    st = cyc;
                end else if (BN == 0) begin
                    m_key = m_tgt;
                    st = cyc;
                end else begin
                    pt = cyc;
                    pl = m_lfsr;
                    for (int i = 0; i < BN; i++) begin
                        piv = (pl[3:0] == 4'd0) ? 1 : int'(pl[3:0]);
                        for (int k = 0; k < piv; k++) pl = lstep(pl);
                        pt += piv;
                        tq.push_back(pt);
                    end
                    fin_t = pt + 1;
                    st = fin_t;
                end
                done_t = st + (m_tgt ? RS : PS);
                idle_t = done_t + 1;
                active = 1;
                m_busy = 1'b1;
            end
            m_lfsr = lstep(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("key", 32'(key), 32'(m_key));
            check("done", 32'(done), 32'(m_done));
            check("busy", 32'(busy), 32'(m_busy));
            check("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !rst));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic wav_a[0:399];
    logic wav_b[0:399];

    // Issue one command to the main DUT and observe it until done.
    task automatic op(input logic p, input int rec, output int e, output int ln,
                      output int dn, output int badgap);
        logic pk;
        int   n;
        int   ns[$];
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_press = p;
        pk = key;
        tick();
        cmd_valid = 1'b0;
        e = 0; ln = -1; dn = -1; badgap = 0; n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (n < 400) begin
                if (rec == 1) wav_a[n] = key;
                if (rec == 2) wav_b[n] = key;
            end
            if (key !== pk) begin
                e++;
                ln = n;
                ns.push_back(n);
            end
            pk = key;
            if (done === 1'b1) begin
                dn = n;
                break;
            end
            n++;
        end
        if (dn < 0) check("op_timeout", 32'(n), 32'd0);
        if (ns.size() == BN + 1) begin
            for (int i = 0; i < BN; i++) begin
                piv = (i == 0) ? ns[0] : ns[i] - ns[i-1];
                if (piv < 1 || piv > 15) badgap++;
            end
            if (ns[BN] - ns[BN-1] != 1) badgap++;
        end
    endtask

    initial begin
        int e, ln, dn, bg, dn_a, n, diffs, kchg;

        check("model_lfsr_step", 32'(lstep(16'hACE1)), 32'h59C3);

        repeat (3) tick();
        check("rst_key", 32'(key), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready_low", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick();

        op(1'b1, 1, e, ln, dn, bg);
        dn_a = dn;
        check("press_edges", 32'(e), 32'd11);
        check("press_settle", 32'(dn - ln), 32'd100);
        check("press_intervals", 32'(bg), 32'd0);
        check("press_key_low", 32'(key), 32'd0);
        check("press_ready_in_done", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("press_ready_after", 32'(cmd_ready), 32'd1);
        tick();

        op(1'b0, 0, e, ln, dn, bg);
        check("release_edges", 32'(e), 32'd11);
        check("release_settle", 32'(dn - ln), 32'd200);
        check("release_intervals", 32'(bg), 32'd0);
        check("release_key_high", 32'(key), 32'd1);
        tick();

        op(1'b0, 0, e, ln, dn, bg);
        check("redundant_edges", 32'(e), 32'd0);
        check("redundant_done_at", 32'(dn), 32'd200);
        tick();

        // Abort mid-bounce, then replay the first press from the same reset point.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        cmd_valid = 1'b1;
        cmd_press = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (8) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_key", 32'(key), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        op(1'b1, 2, e, ln, dn, bg);
        check("replay_done_at", 32'(dn), 32'(dn_a));
        diffs = 0;
        for (int i = 0; i < 400; i++) begin
            if (i <= dn && i <= dn_a && wav_a[i] !== wav_b[i]) diffs++;
        end
        check("replay_waveform", 32'(diffs), 32'd0);
        tick();

        // No-bounce instance: press, redundant press, release.
        for (int k = 0; k < 3; k++) begin
            cmd_valid0 = 1'b1;
            cmd_press0 = (k < 2);
            tick();
            cmd_valid0 = 1'b0;
            @(negedge clk);
            check("nb_key_after_accept", 32'(key0), (k < 2) ? 32'd0 : 32'd1);
            n = 0;
            kchg = 0;
            while (done0 !== 1'b1 && n < 50) begin
                @(negedge clk);
                if (key0 !== ((k < 2) ? 1'b0 : 1'b1)) kchg++;
                n++;
            end
            check("nb_done_at", 32'(n), (k < 2) ? 32'd7 : 32'd9);
            check("nb_key_stable", 32'(kchg), 32'd0);
            check("nb_ready_in_done", 32'(cmd_ready0), 32'd0);
            @(negedge clk);
            check("nb_ready_after", 32'(cmd_ready0), 32'd1);
            tick();
        end

        // Random traffic: sparse commands, held-valid bursts, rare resets.
        n = 0;
        for (int c = 0; c < 20000; c++) begin
            if (n > 0) begin
                cmd_valid = 1'b1;
                n--;
            end else begin
                cmd_valid = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 199) == 0) n = $urandom_range(20, 400);
            end
            cmd_press = $urandom_range(0, 1);
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_bounce_gen.md
KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

Interface
REQ-001 SHALL have parameter BOUNCE_N, default 10; number of bounce toggles per transition (0 gives a clean single edge).
REQ-002 SHALL have parameter BOUNCE_W, default 4; bit-width of the random bounce interval.
REQ-003 SHALL have parameter PRESS_SETTLE, default 100; cycles held after the press edge.
REQ-004 SHALL have parameter RELEASE_SETTLE, default 200; cycles held after the release edge.
REQ-005 SHALL have parameter SEED, default 16'hACE1; LFSR reset value (0 is replaced by 16'hACE1).
REQ-006 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-008 SHALL have port cmd_valid, input, 1 bit; command request.
REQ-009 SHALL have port cmd_press, input, 1 bit; 1 = press (key to 0), 0 = release (key to 1).
REQ-010 SHALL have port cmd_ready, output, 1 bit; high only in IDLE.
REQ-011 SHALL have port key, output, 1 bit, registered; emulated key line, active-low (idle 1).
REQ-012 SHALL have port busy, output, 1 bit; high in BOUNCE or SETTLE.
REQ-013 SHALL have port done, output, 1 bit, registered; one-cycle pulse when a command completes.

Function
REQ-014 SHALL implement a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every non-reset cycle.
REQ-015 SHALL take each bounce interval from LFSR[BOUNCE_W-1:0] at load time, with value 0 mapped to 1, giving a range of 1..2^BOUNCE_W-1 cycles.
REQ-016 SHALL use the FSM states IDLE, BOUNCE and SETTLE.
REQ-017 SHALL accept a command on a clock edge where cmd_valid and cmd_ready are both high; target = ~cmd_press.
REQ-018 SHALL ignore cmd_valid while busy; commands are neither buffered nor queued.
REQ-019 IDLE accept, target != key, BOUNCE_N > 0: SHALL load toggle count = BOUNCE_N and the first interval, then go to BOUNCE.
REQ-020 IDLE accept, target != key, BOUNCE_N = 0: SHALL set key = target on the next edge and go to SETTLE.
REQ-021 IDLE accept, target == key: SHALL go to SETTLE with no key edge (redundant command still times out and pulses done).
REQ-022 BOUNCE: SHALL decrement the interval counter each cycle; on expiry, toggle key, decrement the toggle count and reload the interval.
REQ-023 BOUNCE: on the cycle after the BOUNCE_N-th toggle, SHALL set key = target and go to SETTLE.
REQ-024 SETTLE: SHALL hold key for PRESS_SETTLE cycles (target 0) or RELEASE_SETTLE cycles (target 1), then pulse done for 1 cycle and return to IDLE.
REQ-025 SHALL produce exactly BOUNCE_N toggles plus a final edge only if the level differs from target, so with BOUNCE_N even each transition has BOUNCE_N+1 key edges.
REQ-026 SHALL allow back-to-back operation: a command on the same cycle done is high is not accepted (busy); acceptance is possible from the following cycle.
REQ-027 SHALL never change key in IDLE.

Reset
REQ-028 With rst high at an edge, the next state SHALL be: key=1, state IDLE, done=0, busy=0, LFSR=SEED (or 16'hACE1 if SEED is 0), all counters 0.
REQ-029 SHALL keep cmd_ready low while rst is high, and accept no command on a reset edge.
REQ-030 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort the operation with no done pulse, and key SHALL return to 1 on that edge.
REQ-031 Two runs from the same SEED and same command timing SHALL produce a cycle-identical key waveform.

Verification
REQ-032 Press after reset (defaults): cmd_valid=1, cmd_press=1 -> 11 key edges, key=0 for 100 cycles, done pulses once, cmd_ready returns to 1.
REQ-033 Release after press: cmd_press=0 -> 11 edges, final key=1, done exactly 200 cycles after the final edge.
REQ-034 BOUNCE_N=0 press -> single 1->0 edge one cycle after accept; done after 100 cycles.
REQ-035 Redundant release in idle (key=1) -> no key edges; done pulses 200 cycles after accept.
REQ-036 cmd_valid held high during BOUNCE -> ignored; exactly one done per accepted command; every bounce interval falls within 1..15 cycles.
REQ-037 rst pulse mid-BOUNCE -> key=1 next edge, no done; repeating the press after reset reproduces the waveform of the first press.
